// File: rtl/fb_rd_arbiter.sv
// Frame-buffer read-port arbiter.
// Shares the single registered-read BRAM port between the display scanner, which always
// wins, and a host readout requester that only gets cycles the display leaves idle.
// A two-stage owner tag travels beside each read so returned data can be steered to
// whoever issued it. Host requests that keep losing to the display raise host_starved.
//
// Handshake semantics (both host channels): a transfer happens on a rising edge where
// valid and ready are both 1. host_req_ready is a pure function of the host FSM state.
// host_rsp_valid, once raised, stays high with data/err stable until host_rsp_ready is seen.
module fb_rd_arbiter #(
    parameter  int DATA_WIDTH   = 12,
    parameter  int DEPTH        = 640*480,
    parameter  int STARVE_LIMIT = 1024,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  disp_req,
    input  logic [ADDR_W-1:0]     disp_addr,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_dout,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic [ADDR_W-1:0]     host_req_addr,
    output logic                  host_rsp_valid,
    input  logic                  host_rsp_ready,
    output logic [DATA_WIDTH-1:0] host_rsp_data,
    output logic                  host_rsp_err,
    output logic                  host_starved,
    output logic                  bram_r_en,
    output logic [ADDR_W-1:0]     bram_r_addr,
    input  logic [DATA_WIDTH-1:0] bram_r_dout,
    output logic [1:0]            dbg_host_state
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {H_IDLE, H_WAIT, H_FLIGHT, H_RESP} host_state_e;
    // DISP_OOR marks a display slot that skipped the BRAM; it still returns a (zero) pixel.
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_DISP_OOR, TAG_HOST} tag_e;

    host_state_e           state_q, state_d;
    logic [ADDR_W-1:0]     host_addr_q, host_addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    tag_e                  tag1_q, tag1_d, tag2_q;
    logic                  bram_en_q, bram_en_d;
    logic [ADDR_W-1:0]     bram_addr_q, bram_addr_d;

    logic disp_in_range;
    logic host_in_range;
    logic host_issue;

    assign disp_in_range = ({1'b0, disp_addr} < DEPTH_X);
    assign host_in_range = ({1'b0, host_req_addr} < DEPTH_X);
    // The host only reaches the BRAM in a cycle the display does not claim.
    assign host_issue    = (state_q == H_WAIT) && !disp_req;

    // Slot decision: display first, then a waiting host read; address holds when idle.
    always_comb begin
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        tag1_d      = TAG_NONE;
        if (disp_req) begin
            if (disp_in_range) begin
                bram_en_d   = 1'b1;
                bram_addr_d = disp_addr;
                tag1_d      = TAG_DISP;
            end else begin
                tag1_d      = TAG_DISP_OOR;
            end
        end else if (host_issue) begin
            bram_en_d   = 1'b1;
            bram_addr_d = host_addr_q;
            tag1_d      = TAG_HOST;
        end
    end

    // BRAM request registers and the owner tag pipeline aligned with the read latency.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
        end else begin
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
        end
    end

    // Host FSM state and its transaction registers.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_q     <= H_IDLE;
            host_addr_q <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            host_addr_q <= host_addr_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Host FSM next state: accept, wait for a free slot, collect the tagged return, respond.
    always_comb begin
        state_d     = state_q;
        host_addr_d = host_addr_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            H_IDLE: begin
                if (host_req_valid) begin
                    host_addr_d = host_req_addr;
                    cnt_d       = '0;
                    if (host_in_range) begin
                        state_d = H_WAIT;
                    end else begin
                        // Out-of-range reads never touch the BRAM; answer immediately.
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = H_RESP;
                    end
                end
            end
            H_WAIT: begin
                if (!disp_req) begin
                    state_d = H_FLIGHT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            H_FLIGHT: begin
                if (tag2_q == TAG_HOST) begin
                    rsp_data_d = bram_r_dout;
                    rsp_err_d  = 1'b0;
                    state_d    = H_RESP;
                end
            end
            H_RESP: begin
                if (host_rsp_ready) begin
                    state_d = H_IDLE;
                end
            end
            default: state_d = H_IDLE;
        endcase
    end

    // Outputs derived from FSM state, the tag pipeline and the request registers.
    always_comb begin
        host_req_ready = (state_q == H_IDLE);
        host_rsp_valid = (state_q == H_RESP);
        host_rsp_data  = rsp_data_q;
        host_rsp_err   = rsp_err_q;
        host_starved   = (state_q == H_WAIT) && (cnt_q >= LIMIT_CNT);
        disp_valid     = (tag2_q == TAG_DISP) || (tag2_q == TAG_DISP_OOR);
        disp_dout      = (tag2_q == TAG_DISP) ? bram_r_dout : '0;
        bram_r_en      = bram_en_q;
        bram_r_addr    = bram_addr_q;
        dbg_host_state = state_q;
    end

endmodule

// File: tb/tb_fb_rd_arbiter.sv
// Bench for fb_rd_arbiter: directed stimulus with a BRAM model whose contents are a
// fixed function of the address; expected display pixels and host responses are queued
// by the drivers and checked by a negedge monitor.
module tb_fb_rd_arbiter;

    localparam int DW    = 12;
    localparam int DEPTH = 640*480;
    localparam int AW    = $clog2(DEPTH);

    logic          r_clk = 1'b0;
    logic          r_rst = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_dout;
    logic          host_req_valid = 1'b0;
    logic          host_req_ready;
    logic [AW-1:0] host_req_addr = '0;
    logic          host_rsp_valid;
    logic          host_rsp_ready = 1'b0;
    logic [DW-1:0] host_rsp_data;
    logic          host_rsp_err;
    logic          host_starved;
    logic          bram_r_en;
    logic [AW-1:0] bram_r_addr;
    logic [DW-1:0] bram_r_dout = '0;
    logic [1:0]    dbg_host_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] exp_disp_q[$];
    int            exp_cyc_q[$];
    logic [DW:0]   exp_host_q[$];

    logic [DW-1:0] mon_d;
    int            mon_c;

    fb_rd_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(1024)) dut (
        .r_clk(r_clk), .r_rst(r_rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_dout(disp_dout),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_addr(host_req_addr),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
        .host_starved(host_starved),
        .bram_r_en(bram_r_en), .bram_r_addr(bram_r_addr), .bram_r_dout(bram_r_dout),
        .dbg_host_state(dbg_host_state)
    );

    // ---------------- clock / reset ----------------
    always #5 r_clk = ~r_clk;
    always @(posedge r_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // BRAM contents: address 100 holds 0xABC, everything else holds addr*3.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] p;
        if (a == AW'(100)) return 12'hABC;
        p = 32'(a) * 32'd3;
        return p[DW-1:0];
    endfunction

    // Registered-read BRAM model, one cycle from r_en to r_dout.
    always @(posedge r_clk) begin
        if (bram_r_en) bram_r_dout <= mem_word(bram_r_addr);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge r_clk) begin
        if (disp_valid) begin
            if (exp_disp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL disp_unexpected: disp_valid=1 dout=0x%0h at cycle %0d, expected none",
                         disp_dout, cyc);
            end else begin
                mon_d = exp_disp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                chk("disp_dout", 32'(disp_dout), 32'(mon_d));
                chk("disp_cycle", cyc, mon_c);
            end
        end else if (!r_rst) begin
            chk("disp_dout_idle_zero", 32'(disp_dout), 32'd0);
        end
        if (host_rsp_valid) begin
            if (exp_host_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL host_rsp_unexpected: valid=1 err=%0b data=0x%0h at cycle %0d, expected none",
                         host_rsp_err, host_rsp_data, cyc);
            end else begin
                chk("host_rsp_err_data", 32'({host_rsp_err, host_rsp_data}), 32'(exp_host_q[0]));
                if (host_rsp_ready) void'(exp_host_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic push_disp(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        disp_req  = 1'b1;
        disp_addr = a;
        exp_disp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 2);
    endtask

    task automatic host_accept(input logic [AW-1:0] a, input logic [DW:0] exp, output int t);
        host_req_valid = 1'b1;
        host_req_addr  = a;
        chk("host_req_ready_at_accept", 32'(host_req_ready), 32'd1);
        exp_host_q.push_back(exp);
        t = cyc;
        tick();
        host_req_valid = 1'b0;
    endtask

    task automatic wait_host_valid(output int at);
        bit found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (host_rsp_valid) begin
                found = 1'b1;
                break;
            end
            chk("host_req_ready_busy", 32'(host_req_ready), 32'd0);
            tick();
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL host_rsp_timeout: no host_rsp_valid within 50 cycles (cycle %0d)", cyc);
        end
        at = cyc;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int at;

        // Reset held two cycles: every output idle, host ready.
        r_rst = 1'b1;
        tick();
        tick();
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_disp_dout", 32'(disp_dout), 32'd0);
        chk("rst_host_req_ready", 32'(host_req_ready), 32'd1);
        chk("rst_host_rsp_valid", 32'(host_rsp_valid), 32'd0);
        chk("rst_host_rsp_data", 32'(host_rsp_data), 32'd0);
        chk("rst_host_rsp_err", 32'(host_rsp_err), 32'd0);
        chk("rst_host_starved", 32'(host_starved), 32'd0);
        chk("rst_bram_r_en", 32'(bram_r_en), 32'd0);
        chk("rst_bram_r_addr", 32'(bram_r_addr), 32'd0);
        chk("rst_state", 32'(dbg_host_state), 32'd0);
        r_rst = 1'b0;
        tick();

        // Display stream, addresses 0..9 back-to-back.
        for (int i = 0; i < 10; i++) begin
            push_disp(AW'(i), DW'(i * 3));
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();

        // Host read on an idle port, response held for five cycles.
        host_rsp_ready = 1'b0;
        host_accept(AW'(100), {1'b0, 12'hABC}, t);
        wait_host_valid(at);
        chk("host_latency_idle", at - t, 4);
        for (int k = 0; k < 5; k++) begin
            chk("host_rsp_valid_held", 32'(host_rsp_valid), 32'd1);
            chk("host_req_ready_held", 32'(host_req_ready), 32'd0);
            tick();
        end
        host_rsp_ready = 1'b1;
        tick();
        host_rsp_ready = 1'b0;
        chk("host_rsp_valid_after_ack", 32'(host_rsp_valid), 32'd0);
        chk("host_req_ready_after_ack", 32'(host_req_ready), 32'd1);
        tick();

        // Contention: display holds the port for 2000 cycles after the host is accepted.
        host_rsp_ready = 1'b1;
        host_accept(AW'(200), {1'b0, 12'h258}, t);
        for (int j = 0; j < 2000; j++) begin
            push_disp(AW'(j % 64), DW'((j % 64) * 3));
            if (j == 0 || j == 1023 || j == 1024 || j == 1999)
                chk($sformatf("host_starved_wait%0d", j), 32'(host_starved), 32'(j >= 1024));
            tick();
        end
        disp_req = 1'b0;
        chk("host_starved_before_issue", 32'(host_starved), 32'd1);
        tick();
        chk("host_starved_after_issue", 32'(host_starved), 32'd0);
        wait_host_valid(at);
        chk("host_latency_after_contention", at - (t + 2001), 3);
        repeat (4) tick();

        // Out-of-range host and display addresses never enable the BRAM.
        host_accept(AW'(DEPTH), {1'b1, 12'h000}, t);
        chk("host_oor_rsp_next_cycle", 32'(host_rsp_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bram_r_en_host_oor", 32'(bram_r_en), 32'd0);
            tick();
        end
        push_disp(AW'(DEPTH + 5), 12'h000);
        tick();
        disp_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bram_r_en_disp_oor", 32'(bram_r_en), 32'd0);
            tick();
        end

        // Reset pulse while a host read is in flight drops it completely.
        host_rsp_ready = 1'b0;
        host_accept(AW'(50), {1'b0, 12'd150}, t);
        tick();
        chk("state_in_flight", 32'(dbg_host_state), 32'd2);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        exp_host_q.delete();
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
            chk("post_rst_req_ready", 32'(host_req_ready), 32'd1);
            tick();
        end

        // Normal service resumes after the reset.
        host_rsp_ready = 1'b1;
        host_accept(AW'(7), {1'b0, 12'd21}, t);
        wait_host_valid(at);
        chk("host_latency_post_rst", at - t, 4);
        repeat (3) tick();

        chk("disp_queue_drained", exp_disp_q.size(), 0);
        chk("host_queue_drained", exp_host_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
